// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;
  typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, WAIT = 2'd2} fetch_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {pc, instr} holding slot with synchronous flush.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output logic         full,
  output fetch_entry_t dout
);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      full <= 1'b0;
      dout <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
      dout <= din;
    end else if (pop) begin
      full <= 1'b0;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer with one outstanding imem read, redirects and decode backpressure.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] pc_q,
  output logic [31:0] pc_next,
  output logic        pc_wen,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        exc_misalign
);
  fetch_state_e state, state_nxt;
  fetch_entry_t skid_q;
  logic        kill, kill_nxt, exc_q;
  logic        redir, hs, rsp, rsp_take, out_free, skid_full, skid_push, skid_pop;
  logic [31:0] req_pc, instr_q, redir_target;
  assign redir          = redirect_valid && state != BOOT;
  assign imem_req_valid = state == FETCH && !skid_full && !redirect_valid && !exc_q;
  assign imem_addr      = pc_q;
  assign hs             = imem_req_valid && imem_req_ready;
  assign rsp            = state == WAIT && imem_rsp_valid;
  assign rsp_take       = rsp && !kill && !redir;
  assign out_free       = !id_valid || id_ready;
  assign skid_push      = rsp_take && !out_free;
  assign skid_pop       = !redir && skid_full && out_free;
  // BOOT is the reset state, so the write enable is also masked by rstn itself
  assign pc_wen         = rstn && (state == BOOT || redir || hs);
  assign pc_next        = state == BOOT ? RESET_PC : redir ? redir_target : pc_q + PC_STEP;
  assign id_instr       = id_valid ? instr_q : NOP_INSTR;
  assign exc_misalign   = exc_q;
`ifdef FETCH_MISALIGN_EN
  assign redir_target = redirect_pc;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) exc_q <= 1'b0;
    else if (redir && |redirect_pc[1:0]) exc_q <= 1'b1;
`else
  assign redir_target = redirect_pc & ~32'd3;
  assign exc_q        = 1'b0;
`endif
  always_comb begin
    state_nxt = state == BOOT  ? FETCH :
                state == FETCH ? (hs ? WAIT : FETCH) :
                                 (imem_rsp_valid ? FETCH : WAIT);
    // a redirect with the response already here drops it directly, no kill needed
    kill_nxt  = redir       ? (kill || (state == WAIT && !imem_rsp_valid)) :
                (rsp && kill) ? 1'b0 : kill;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state    <= BOOT;
      kill     <= 1'b0;
      req_pc   <= '0;
      id_valid <= 1'b0;
      id_pc    <= '0;
      instr_q  <= NOP_INSTR;
    end else begin
      state <= state_nxt;
      kill  <= kill_nxt;
      if (hs) req_pc <= pc_q;
      if (redir) id_valid <= 1'b0;
      else if (out_free) begin
        id_valid <= skid_full || rsp_take;
        if (skid_full) begin
          id_pc   <= skid_q.pc;
          instr_q <= skid_q.instr;
        end else if (rsp_take) begin
          id_pc   <= req_pc;
          instr_q <= imem_rsp_data;
        end
      end
    end
  fetch_skid_buf u_skid (
    .clk  (clk),
    .rstn (rstn),
    .flush(redir),
    .push (skid_push),
    .pop  (skid_pop),
    .din  ('{pc: req_pc, instr: imem_rsp_data}),
    .full (skid_full),
    .dout (skid_q)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks with a PC register and fixed-latency imem model.
module tb_fetch_unit;
  import fetch_pkg::*;
  logic        clk = 1'b0, rstn = 1'b0;
  logic [31:0] pc_q, pc_next, imem_addr, imem_rsp_data, redirect_pc, id_pc, id_instr;
  logic        pc_wen, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        redirect_valid, id_valid, id_ready, exc_misalign;
  logic        pending;
  logic [31:0] maddr;
  int          cnt, rsp_delay = 1, checks = 0, errors = 0;

  fetch_unit dut (
    .clk(clk), .rstn(rstn), .pc_q(pc_q), .pc_next(pc_next), .pc_wen(pc_wen),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
    .exc_misalign(exc_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) pc_q <= '0;
    else if (pc_wen) pc_q <= pc_next;

  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      pending <= 1'b0;
      cnt     <= 0;
      maddr   <= '0;
    end else if (imem_req_valid && imem_req_ready) begin
      pending <= 1'b1;
      cnt     <= rsp_delay;
      maddr   <= imem_addr;
    end else if (pending) begin
      if (cnt == 1) pending <= 1'b0;
      else cnt <= cnt - 1;
    end

  assign imem_rsp_valid = pending && cnt == 1;
  assign imem_rsp_data  = mem(maddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_xfer(input string tag, input logic [31:0] exp_pc);
    int n = 0;
    while (!(id_valid && id_ready) && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(id_valid && id_ready), 32'd1);
    chk({tag, "_pc"}, id_pc, exp_pc);
    chk({tag, "_instr"}, id_instr, mem(exp_pc));
    tick();
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!(imem_req_valid && imem_req_ready) && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_req_seen"}, 32'(imem_req_valid && imem_req_ready), 32'd1);
  endtask

  initial begin
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_instr", id_instr, NOP_INSTR);
    chk("rst_exc", 32'(exc_misalign), 32'd0);
    chk("rst_pc_wen", 32'(pc_wen), 32'd0);
    chk("rst_req", 32'(imem_req_valid), 32'd0);
    // release reset with a redirect that BOOT must ignore
    rstn = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_8000;
    #1;
    chk("boot_wen", 32'(pc_wen), 32'd1);
    chk("boot_next", pc_next, 32'h0000_3000);
    chk("boot_req", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("f0_req", 32'(imem_req_valid), 32'd1);
    chk("f0_addr", imem_addr, 32'h0000_3000);
    chk("f0_next", pc_next, 32'h0000_3004);
    chk("f0_wen", 32'(pc_wen), 32'd1);
    wait_xfer("t1a", 32'h0000_3000);
    wait_xfer("t1b", 32'h0000_3004);
    wait_xfer("t1c", 32'h0000_3008);
    // decode stall: one instr held, one in skid, then requests stop
    id_ready = 1'b0;
    for (int n = 0; n < 30 && !id_valid; n++) tick();
    chk("t2_hold_pc0", id_pc, 32'h0000_300C);
    repeat (5) tick();
    chk("t2_hold_valid", 32'(id_valid), 32'd1);
    chk("t2_hold_pc", id_pc, 32'h0000_300C);
    chk("t2_hold_instr", id_instr, mem(32'h0000_300C));
    chk("t2_no_req", 32'(imem_req_valid), 32'd0);
    id_ready = 1'b1;
    #1;
    chk("t2_d1_valid", 32'(id_valid), 32'd1);
    chk("t2_d1_pc", id_pc, 32'h0000_300C);
    tick();
    chk("t2_d2_valid", 32'(id_valid), 32'd1);
    chk("t2_d2_pc", id_pc, 32'h0000_3010);
    chk("t2_d2_instr", id_instr, mem(32'h0000_3010));
    tick();
    // redirect while waiting on a 2-cycle response
    rsp_delay = 2;
    wait_req("t3");
    tick();
    rsp_delay = 1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_4000;
    #1;
    chk("t3_wen", 32'(pc_wen), 32'd1);
    chk("t3_next", pc_next, 32'h0000_4000);
    tick();
    redirect_valid = 1'b0;
    #1;
    wait_xfer("t3", 32'h0000_4000);
    // redirect coinciding with the response
    for (int n = 0; n < 30 && !imem_rsp_valid; n++) tick();
    chk("t4_rsp_seen", 32'(imem_rsp_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_5000;
    #1;
    chk("t4_next", pc_next, 32'h0000_5000);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t4_req", 32'(imem_req_valid), 32'd1);
    chk("t4_addr", imem_addr, 32'h0000_5000);
    wait_xfer("t4a", 32'h0000_5000);
    wait_xfer("t4b", 32'h0000_5004);
    // PC wrap-around
    wait_req("t5");
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    #1;
    chk("t5_noreq", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
    chk("t5_next", pc_next, 32'h0000_0000);
    chk("t5_wen", 32'(pc_wen), 32'd1);
    wait_xfer("t5a", 32'hFFFF_FFFC);
    wait_xfer("t5b", 32'h0000_0000);
    // misaligned redirect
    wait_req("t6");
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_4002;
    #1;
`ifdef FETCH_MISALIGN_EN
    chk("t6_next", pc_next, 32'h0000_4002);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t6_exc", 32'(exc_misalign), 32'd1);
    chk("t6_noreq", 32'(imem_req_valid), 32'd0);
    repeat (3) tick();
    chk("t6_exc_hold", 32'(exc_misalign), 32'd1);
    chk("t6_noreq_hold", 32'(imem_req_valid), 32'd0);
`else
    chk("t6_next", pc_next, 32'h0000_4000);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t6_addr", imem_addr, 32'h0000_4000);
    chk("t6_exc", 32'(exc_misalign), 32'd0);
    wait_xfer("t6", 32'h0000_4000);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
